// File: rtl/pwm_out_pkg.sv
// pwm_out_pkg -- shared constants and types for the PWM output bank.
//   DEF_N_CH / DEF_CNT_W / DEF_PRE_W : default channel count and widths
//   dir_e                           : counter direction (DIR_UP / DIR_DOWN)
//   ch_idx_w()                      : width of a channel index (at least 1 bit)
package pwm_out_pkg;

  localparam int DEF_N_CH  = 7;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_PRE_W = 8;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler -- divides clk down to a one-clock tick.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   presc : tick is raised once every presc+1 clocks (presc=0 -> every clock)
//   tick  : combinational, high while the prescale count equals presc
module pwm_prescaler #(
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PRE_W-1:0] presc,
  output logic             tick
);

  localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

  logic [PRE_W-1:0] pre_cnt;

  assign tick = (pre_cnt == presc);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_ONE;
    end
  end

endmodule

// File: rtl/pwm_out_bank.sv
// pwm_out_bank -- bank of N_CH PWM outputs sharing one period counter.
//   clk, rst_n   : clock (rising edge), synchronous active-low reset
//   presc        : counter advances once every presc+1 clocks
//   period       : period is period+1 counts; loaded only at a period boundary
//   sel_pwm      : per channel, 1 = PWM, 0 = static value from ovalues
//   invert       : per-channel output inversion
//   ovalues      : static output values
//   cfg_valid/cfg_ready/cfg_ch/cfg_duty : duty write channel
//   period_tick  : registered one-clock pulse after each period boundary
//   opins        : registered channel outputs
//   center       : only with PWM_OUT_BANK_CENTER_EN defined; 1 = up/down
//                  (center-aligned) counting, 0 = edge-aligned
//
// Duty handshake: a write transfers on a clock edge where cfg_valid and
// cfg_ready are both high. cfg_ready is ~pending: after a transfer it stays
// low until the next period boundary copies the shadow duties into the active
// duties, so at most one update is in flight per period. A write to a channel
// index >= N_CH still transfers but changes nothing, including pending.
module pwm_out_bank
  import pwm_out_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PRE_W-1:0]            presc,
  input  logic [CNT_W-1:0]            period,
  input  logic [N_CH-1:0]             sel_pwm,
  input  logic [N_CH-1:0]             invert,
  input  logic [N_CH-1:0]             ovalues,
`ifdef PWM_OUT_BANK_CENTER_EN
  input  logic                        center,
`endif
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [ch_idx_w(N_CH)-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]            cfg_duty,
  output logic                        period_tick,
  output logic [N_CH-1:0]             opins
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             tick;
  logic             center_on;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] period_act;
  dir_e             dir;
  dir_e             dir_nxt;
  logic             boundary;
  logic             pending;
  logic             accept;
  logic             ch_ok;
  logic [N_CH-1:0]  opins_nxt;
  logic [CNT_W-1:0] duty_shadow [N_CH];
  logic [CNT_W-1:0] duty_act    [N_CH];

  pwm_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .presc (presc),
    .tick  (tick)
  );

`ifdef PWM_OUT_BANK_CENTER_EN
  assign center_on = center;
`else
  assign center_on = 1'b0;
`endif

  // Counter state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      dir         <= DIR_UP;
      period_act  <= '1;
      period_tick <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      dir         <= dir_nxt;
      period_tick <= boundary;
      if (boundary) period_act <= period;
    end
  end

  // Counter next state. In center mode the boundary is the tick taken at
  // cnt==0 while counting down; a zero-length period makes every tick a
  // boundary regardless of direction. After a center boundary the count
  // resumes at 1 so the value 0 occurs once per period.
  always_comb begin
    boundary = 1'b0;
    cnt_nxt  = cnt;
    dir_nxt  = dir;
    if (tick) begin
      if (center_on) begin
        if (cnt == '0 && (dir == DIR_DOWN || period_act == '0)) begin
          boundary = 1'b1;
          cnt_nxt  = (period == '0) ? '0 : CNT_ONE;
          dir_nxt  = DIR_UP;
        end else if (dir == DIR_UP) begin
          if (cnt == period_act) begin
            cnt_nxt = cnt - CNT_ONE;
            dir_nxt = DIR_DOWN;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end else begin
        dir_nxt = DIR_UP;
        if (cnt == period_act) begin
          boundary = 1'b1;
          cnt_nxt  = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
    end
  end

  // Duty write path.
  assign cfg_ready = ~pending;
  assign accept    = cfg_valid & cfg_ready;
  assign ch_ok     = (int'(cfg_ch) < N_CH);

  // A write in the boundary cycle wins over the boundary's pending clear, and
  // duty_act takes the shadow value from before that write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        duty_shadow[i] <= '0;
        duty_act[i]    <= '0;
      end
    end else begin
      if (boundary) pending <= 1'b0;
      if (accept && ch_ok) pending <= 1'b1;
      for (int i = 0; i < N_CH; i++) begin
        if (boundary) duty_act[i] <= duty_shadow[i];
        if (accept && ch_ok && int'(cfg_ch) == i) duty_shadow[i] <= cfg_duty;
      end
    end
  end

  // Per-channel compare and output select.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic pwm_bit;
    assign pwm_bit      = (cnt < duty_act[g]);
    assign opins_nxt[g] = (sel_pwm[g] ? pwm_bit : ovalues[g]) ^ invert[g];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) opins <= '0;
    else        opins <= opins_nxt;
  end

endmodule
